// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter: round-robin shared UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined)
// ports: clk_50M clock, rst async active-high reset,
//        req_valid/req_data/req_ready per-requester byte handshake (byte i at req_data[8i+7:8i]),
//        tx serial line (idle high), busy frame in flight, grant_id last winner,
//        frame_done one-cycle pulse in the final stop-bit cycle
module uart_tx_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int CLK_DIV = 5208,
  parameter int DIV_W = 13,
  parameter int ID_W = 2
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic              frame_done
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [DIV_W-1:0] timer, timer_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] byte_q;
  logic [ID_W-1:0] ptr, win, ptr_n;
  logic [ID_W:0] sum, nxt;
  logic [NREQ-1:0] rot;
  logic any, last, tx_n, grant;
  // Rotate valids so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> ptr);
    any = 1'b0;
    sum = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (ID_W+1)'(k);
      end
    win = sum >= (ID_W+1)'(NREQ) ? ID_W'(sum - (ID_W+1)'(NREQ)) : sum[ID_W-1:0];
    nxt = {1'b0, win} + 1'b1;
    ptr_n = nxt == (ID_W+1)'(NREQ) ? '0 : nxt[ID_W-1:0];
  end
  assign grant = state == IDLE && any && !rst;
  assign req_ready = grant ? NREQ'(1) << win : '0;
  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n = bit_cnt;
    last = timer == DIV_W'(CLK_DIV-1);
    if (state == IDLE) begin
      timer_n = '0;
      bit_n = '0;
      if (any) state_n = START;
    end else begin
      timer_n = last ? '0 : timer + 1'b1;
      if (last)
        case (state)
          START: state_n = DATA;
          DATA: begin
            bit_n = bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_cnt == 3'd7) state_n = PARITY;
`else
            if (bit_cnt == 3'd7) state_n = STOP;
`endif
          end
`ifdef UART_TX_PARITY_EN
          PARITY: state_n = STOP;
`endif
          default: state_n = IDLE;
        endcase
    end
  end
  // tx is registered, so it is derived from the state being entered, not the current one.
`ifdef UART_TX_PARITY_EN
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? byte_q[bit_n] : state_n == PARITY ? ^byte_q : 1'b1;
`else
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? byte_q[bit_n] : 1'b1;
`endif
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      bit_cnt <= '0;
      byte_q <= '0;
      ptr <= '0;
      grant_id <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      bit_cnt <= bit_n;
      tx <= tx_n;
      busy <= state_n != IDLE;
      frame_done <= state_n == STOP && timer_n == DIV_W'(CLK_DIV-1);
      if (grant) begin
        byte_q <= req_data[{win, 3'b000} +: 8];
        grant_id <= win;
        ptr <= ptr_n;
      end
    end
endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// tb_uart_tx_rr_arbiter: randomized scoreboard bench with serial-line receiver
module tb_uart_tx_rr_arbiter;
  localparam int NREQ = 4, CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk_50M = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic tx, busy, frame_done;
  logic [1:0] grant_id;
  uart_tx_rr_arbiter #(.NREQ(NREQ), .CLK_DIV(CLK_DIV), .DIV_W(13), .ID_W(2)) dut (
    .clk_50M(clk_50M), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done));
  always #10 clk_50M = ~clk_50M;
  typedef struct {int id; logic [7:0] b;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cnt = 0, ptr = 0, mode = 0;
  bit run = 0, rx_busy = 0;
  logic [NREQ-1:0] acc = '0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: the line is busy for NB*CLK_DIV cycles after each grant; when free,
  // the first valid requester at or after the pointer (cyclically) wins.
  always @(negedge clk_50M) if (run) begin
    logic [NREQ-1:0] er;
    er = '0;
    if (cnt > 0) cnt--;
    else if (req_valid != 0) begin
      int w;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_valid[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
      er[w] = 1'b1;
      q.push_back('{w, req_data[8*w +: 8]});
      ptr = (w + 1) % NREQ;
      cnt = NB * CLK_DIV;
    end
    chk("req_ready", req_ready, er);
    acc = req_valid & req_ready;
  end
  // Serial receiver: decodes each frame from the tx line and checks it against the queue.
  initial forever begin
    @(negedge clk_50M);
    if (run && tx === 1'b0) begin
      exp_t e;
      logic [7:0] b;
      rx_busy = 1;
      e = '{-1, 8'h00};
      b = '0;
      chk("frame_expected", q.size() != 0, 1);
      if (q.size() != 0) e = q.pop_front();
      chk("busy_start", busy, 1);
      chk("grant_id", grant_id, e.id);
      chk("frame_done_start", frame_done, 0);
      for (int o = 1; o <= NB * CLK_DIV; o++) begin
        @(negedge clk_50M);
        if (o == NB * CLK_DIV) begin
          chk("busy_end", busy, 0);
          chk("tx_idle_gap", tx, 1);
        end else begin
          chk("frame_done", frame_done, o == NB * CLK_DIV - 1);
          if (o % CLK_DIV == CLK_DIV / 2) begin
            if (o / CLK_DIV == 0) chk("start_bit", tx, 0);
            else if (o / CLK_DIV <= 8) b[o / CLK_DIV - 1] = tx;
            else if (o / CLK_DIV == NB - 1) chk("stop_bit", tx, 1);
            else chk("parity_bit", tx, ^e.b);
          end
        end
      end
      chk("byte", b, e.b);
      rx_busy = 0;
    end
  end
  initial begin
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    repeat (2) @(negedge clk_50M);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1 chk("first_ready", req_ready, 4'b0100);
    @(posedge clk_50M);
    #1 req_valid = '0;
    chk("ready_after_grant", req_ready, 0);
    repeat (12) @(negedge clk_50M);
    chk("mid_busy", busy, 1);
    chk("mid_grant_id", grant_id, 2);
    chk("mid_data_bit1", tx, 0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_req_ready", req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_50M);
      chk("midrst_frame_done", frame_done, 0);
    end
    rst = 1'b0;
    #1 run = 1;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk_50M);
      #1;
      if (c % 1500 == 0) mode = $urandom_range(0, 2);
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = mode == 0 || $urandom_range(0, mode == 1 ? 3 : 1) == 0;
          req_data[8*i +: 8] = 8'($urandom);
        end
    end
    @(posedge clk_50M);
    #1 req_valid = '0;
    for (int c = 0; c < 2000 && (q.size() != 0 || cnt != 0 || rx_busy); c++) @(negedge clk_50M);
    chk("drain_queue", q.size(), 0);
    chk("drain_rx", rx_busy, 0);
    repeat (2) @(negedge clk_50M);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
